// File: rtl/des_pkg.sv
// Shared DES constants: block width and the IP / IP^-1 bit-selection tables.
// Both tables use DES numbering: entry n gives the input bit (1 = MSB) that
// feeds output bit n.
package des_pkg;

  localparam int BLOCK_W = 64;

  localparam int IP_TABLE [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int IP_INV_TABLE [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

endpackage

// File: rtl/des_perm64.sv
// One 64-bit lane of the DES initial permutation or its inverse.
// Pure wiring: mode_i only selects which table drives each output bit.
module des_perm64
  import des_pkg::*;
(
  input  logic [1:BLOCK_W] data_i,
  input  logic             mode_i,
  output logic [1:BLOCK_W] data_o
);

  // out[n] = in[T[n]], T chosen by mode (0 = IP, 1 = IP^-1)
  always_comb begin
    data_o = '0;
    for (int n = 1; n <= BLOCK_W; n++) begin
      data_o[n] = mode_i ? data_i[IP_INV_TABLE[n]] : data_i[IP_TABLE[n]];
    end
  end

endmodule

// File: rtl/des_ip_perm_pipe.sv
// Multi-lane DES IP / IP^-1 with a STAGES-deep valid/ready pipeline behind
// the combinational permutation, plus a wrapping count of delivered lanes.
// Back-pressure is a combinational chain from ready_i to ready_o; bubbles
// collapse because each stage reloads whenever it is empty.
module des_ip_perm_pipe
  import des_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     mode_i,
  input  logic [1:BLOCK_W*LANES]   data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [1:BLOCK_W*LANES]   data_o,
  output logic                     mode_o,
  output logic [CNT_W-1:0]         blk_cnt_o
);

  localparam int DW = BLOCK_W * LANES;

  logic [1:DW]     perm_d;
  logic [1:STAGES] v;
  logic [1:STAGES] m;
  logic [1:STAGES] load;
  logic [1:DW]     d [1:STAGES];
  logic            chain;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    des_perm64 u_perm (
      .data_i (data_i[BLOCK_W*k+1 +: BLOCK_W]),
      .mode_i (mode_i),
      .data_o (perm_d[BLOCK_W*k+1 +: BLOCK_W])
    );
  end

  // load[s]: stage s takes from s-1 when empty or when it is emptying downstream
  always_comb begin
    load  = '0;
    chain = ready_i;
    for (int s = STAGES; s >= 1; s--) begin
      load[s] = !v[s] || chain;
      chain   = load[s];
    end
  end

  assign ready_o = load[1];
  assign valid_o = v[STAGES];
  assign data_o  = d[STAGES];
  assign mode_o  = m[STAGES];

  // stage registers; data/mode only move when a real beat moves, so stalls hold bit-stable
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      m <= '0;
      for (int s = 1; s <= STAGES; s++) d[s] <= '0;
    end else begin
      if (load[1]) begin
        v[1] <= valid_i;
        if (valid_i) begin
          d[1] <= perm_d;
          m[1] <= mode_i;
        end
      end
      for (int s = 2; s <= STAGES; s++) begin
        if (load[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) begin
            d[s] <= d[s-1];
            m[s] <= m[s-1];
          end
        end
      end
    end
  end

  // delivered-lane counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) blk_cnt_o <= '0;
    else if (valid_o && ready_i) blk_cnt_o <= blk_cnt_o + CNT_W'(LANES);
  end

endmodule

// File: tb/tb_des_ip_perm_pipe.sv
// Bench for des_ip_perm_pipe: three configurations share one clock.
//   u1 : LANES=1 STAGES=1  -> known vectors table, random IP/IP^-1 round trips
//   u4 : LANES=4 STAGES=3  -> lane mapping, latency, stall, mode alternation, reset
//   uw : LANES=1 STAGES=2 CNT_W=4 -> counter wrap
// The reference permutation tables are built from the IP row pattern and
// IP^-1 is derived by inverting IP.
module tb_des_ip_perm_pipe;

  typedef struct {
    logic        mode;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic         mode;
    logic [1:256] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int ip_t  [1:64];
  int ipi_t [1:64];

  // u1
  logic        rst1, vi1, ro1, mi1, vo1, mo1;
  logic        ri1 = 1'b1;
  logic [1:64] di1, do1;
  logic [31:0] cnt1;
  // u4
  logic         rst4, vi4, ro4, mi4, vo4, ri4, mo4;
  logic [1:256] di4, do4;
  logic [31:0]  cnt4;
  // uw
  logic        rstw, viw, row, miw, vow, mow;
  logic        riw = 1'b1;
  logic [1:64] diw, dow;
  logic [3:0]  cntw;

  des_ip_perm_pipe #(.LANES(1), .STAGES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst1), .valid_i(vi1), .ready_o(ro1), .mode_i(mi1), .data_i(di1),
    .valid_o(vo1), .ready_i(ri1), .data_o(do1), .mode_o(mo1), .blk_cnt_o(cnt1));

  des_ip_perm_pipe #(.LANES(4), .STAGES(3), .CNT_W(32)) u4 (
    .clk(clk), .rst(rst4), .valid_i(vi4), .ready_o(ro4), .mode_i(mi4), .data_i(di4),
    .valid_o(vo4), .ready_i(ri4), .data_o(do4), .mode_o(mo4), .blk_cnt_o(cnt4));

  des_ip_perm_pipe #(.LANES(1), .STAGES(2), .CNT_W(4)) uw (
    .clk(clk), .rst(rstw), .valid_i(viw), .ready_o(row), .mode_i(miw), .data_i(diw),
    .valid_o(vow), .ready_i(riw), .data_o(dow), .mode_o(mow), .blk_cnt_o(cntw));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] perm(input logic [63:0] x, input logic mode);
    logic [63:0] r;
    int t;
    r = '0;
    for (int n = 1; n <= 64; n++) begin
      t = mode ? ipi_t[n] : ip_t[n];
      r[64-n] = x[64-t];
    end
    return r;
  endfunction

  // ---------------- u4 scoreboard ----------------
  beat_t       sb[$];
  logic [31:0] mcnt4 = '0;
  bit          mon_en = 0;
  bit          prev_stall = 0;
  logic [1:256] prev_d;
  logic        prev_m;

  always @(negedge clk) begin
    beat_t b, e;
    logic [63:0] lane;
    #2;
    if (rst4) begin
      sb.delete();
      mcnt4 = '0;
      prev_stall = 0;
    end else if (mon_en) begin
      chk("u4_ready", ro4, (sb.size() < 3) || ri4);
      chk("u4_cnt", cnt4, mcnt4);
      if (prev_stall) begin
        chk("u4_stall_data", do4, prev_d);
        chk("u4_stall_mode", mo4, prev_m);
      end
      if (vo4 && ri4) begin
        if (sb.size() == 0) begin
          chk("u4_unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("u4_out_data", do4, e.data);
          chk("u4_out_mode", mo4, e.mode);
        end
        mcnt4 = mcnt4 + 32'd4;
      end
      if (vi4 && ro4) begin
        b.mode = mi4;
        for (int k = 0; k < 4; k++) begin
          lane = di4[64*k+1 +: 64];
          b.data[64*k+1 +: 64] = perm(lane, mi4);
        end
        sb.push_back(b);
      end
      prev_stall = vo4 && !ri4;
      prev_d = do4;
      prev_m = mo4;
    end
  end

  // one beat through u1; returns output sampled one cycle later and the count after delivery
  task automatic beat1(input logic m, input logic [63:0] x,
                       output logic [63:0] q, output logic vo, output logic mo,
                       output logic [31:0] c);
    @(negedge clk);
    vi1 = 1'b1; mi1 = m; di1 = x;
    @(negedge clk);
    vi1 = 1'b0;
    q = do1; vo = vo1; mo = mo1;
    @(negedge clk);
    c = cnt1;
  endtask

  task automatic drain4();
    int w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("u4_drain", sb.size(), 0);
  endtask

  // continuous upstream into u4; holds a beat until accepted
  task automatic stream4(input int n, input int stall_at, input int stall_len,
                         input bit alt, output bit saw_low);
    int sent = 0;
    int cyc  = 0;
    bit need = 1;
    saw_low = 0;
    while (sent < n && cyc < 500) begin
      @(negedge clk);
      if (need) begin
        di4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mi4 = alt ? sent[0] : 1'($urandom_range(0, 1));
      end
      vi4 = 1'b1;
      ri4 = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #3;
      if (!ri4 && !ro4) saw_low = 1;
      need = ro4;
      if (ro4) sent++;
      cyc++;
    end
    chk("u4_stream_budget", sent, n);
    @(negedge clk);
    vi4 = 1'b0;
    ri4 = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [6];
    logic [63:0] lanes_in  [4];
    logic [63:0] lanes_exp [4];
    logic [63:0] q, x, y, lane;
    logic        vo, mo;
    logic [31:0] c, mcnt1;
    bit          saw_low;
    int          start;

    for (int r = 0; r < 8; r++) begin
      start = (r < 4) ? 58 + 2*r : 57 + 2*(r-4);
      for (int cc = 0; cc < 8; cc++) ip_t[8*r+cc+1] = start - 8*cc;
    end
    for (int n = 1; n <= 64; n++) ipi_t[ip_t[n]] = n;

    vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA};
    vecs[1] = '{1'b1, 64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF};
    vecs[2] = '{1'b0, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{1'b0, 64'h8000000000000000, 64'h0000000001000000};
    vecs[5] = '{1'b1, 64'h8000000000000000, 64'h0000000000000040};

    lanes_in[0] = 64'h0123456789ABCDEF; lanes_exp[0] = 64'hCC00CCFFF0AAF0AA;
    lanes_in[1] = 64'h0;                lanes_exp[1] = 64'h0;
    lanes_in[2] = 64'hFFFFFFFFFFFFFFFF; lanes_exp[2] = 64'hFFFFFFFFFFFFFFFF;
    lanes_in[3] = 64'h8000000000000000; lanes_exp[3] = 64'h0000000001000000;

    rst1 = 1; rst4 = 1; rstw = 1;
    vi1 = 0; mi1 = 0; di1 = '0;
    vi4 = 0; mi4 = 0; di4 = '0; ri4 = 1;
    viw = 0; miw = 0; diw = '0;
    repeat (3) @(negedge clk);
    rst1 = 0; rst4 = 0; rstw = 0;

    chk("u1_rst_valid", vo1, 0);
    chk("u1_rst_data", do1, 0);
    chk("u1_rst_mode", mo1, 0);
    chk("u1_rst_cnt", cnt1, 0);
    chk("u1_rst_ready", ro1, 1);
    chk("u4_rst_valid", vo4, 0);
    chk("u4_rst_data", do4, 0);
    chk("u4_rst_cnt", cnt4, 0);
    chk("u4_rst_ready", ro4, 1);
    chk("uw_rst_cnt", cntw, 0);
    mon_en = 1;

    // u1: known vectors
    mcnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      beat1(vecs[i].mode, vecs[i].din, q, vo, mo, c);
      mcnt1++;
      chk($sformatf("u1_vec%0d_valid", i), vo, 1);
      chk($sformatf("u1_vec%0d_data", i), q, vecs[i].exp);
      chk($sformatf("u1_vec%0d_mode", i), mo, vecs[i].mode);
      chk($sformatf("u1_vec%0d_cnt", i), c, mcnt1);
    end

    // u1: random IP then IP^-1 round trips
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      beat1(1'b0, x, y, vo, mo, c);
      chk("u1_rand_ip", y, perm(x, 1'b0));
      beat1(1'b1, y, q, vo, mo, c);
      chk("u1_rand_roundtrip", q, x);
      mcnt1 += 2;
    end
    chk("u1_final_cnt", cnt1, mcnt1);

    // u4: lane mapping and latency of exactly 3 cycles
    @(negedge clk);
    vi4 = 1; mi4 = 0; ri4 = 1;
    di4 = {lanes_in[0], lanes_in[1], lanes_in[2], lanes_in[3]};
    @(negedge clk);
    vi4 = 0;
    chk("u4_lat_t1", vo4, 0);
    @(negedge clk);
    chk("u4_lat_t2", vo4, 0);
    @(negedge clk);
    chk("u4_lat_t3", vo4, 1);
    chk("u4_lat_mode", mo4, 0);
    for (int k = 0; k < 4; k++) begin
      lane = do4[64*k+1 +: 64];
      chk($sformatf("u4_lane%0d", k), lane, lanes_exp[k]);
    end
    @(negedge clk);
    chk("u4_cnt_after_lanes", cnt4, 4);

    // u4: stall of 5 cycles mid-stream
    stream4(30, 10, 5, 0, saw_low);
    chk("u4_stall_backpressure", saw_low, 1);
    drain4();

    // u4: alternating mode at full rate
    stream4(20, 1000, 0, 1, saw_low);
    drain4();

    // u4: reset with two beats in flight
    @(negedge clk);
    vi4 = 1; mi4 = 0; di4 = {8{$urandom}};
    @(negedge clk);
    mi4 = 1; di4 = {8{$urandom}};
    @(negedge clk);
    vi4 = 0; rst4 = 1;
    @(negedge clk);
    rst4 = 0;
    chk("u4_rstmid_valid", vo4, 0);
    chk("u4_rstmid_cnt", cnt4, 0);
    chk("u4_rstmid_ready", ro4, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("u4_rstmid_no_out", vo4, 0);
    end

    // uw: 20 single-lane beats into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      viw = 1; miw = 1'(i); diw = {$urandom, $urandom};
      #3;
      chk("uw_ready", row, 1);
    end
    @(negedge clk);
    viw = 0;
    repeat (4) @(negedge clk);
    chk("uw_wrap_cnt", cntw, 4);
    chk("uw_idle", vow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
